int_controller: RTL and testbench
=================================

# int_controller

Four-source interrupt controller that drives the CPU control unit's interrupt inputs. It synchronizes and latches external interrupt sources, applies per-source enables and fixed priority, and presents one request at a time. It tracks the in-service interrupt across the attend/complete handshake and supports tail-chaining on RETI. Software configures and inspects it through a small register port on the data bus.

## Interface
- SYNC_STAGES, 2, synchronizer flops per source input (minimum 2)
- BUS_WIDTH, 32, register port data width
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous, active-low reset
- i_IrqSrc  in  4  raw interrupt sources, asynchronous to i_Clk; bit 0 has the highest priority
- i_IntAckAttended  in  1  control unit has taken the request (one-cycle pulse)
- i_IntAckComplete  in  1  RETI is executing (one-cycle pulse)
- o_IntRequest  out  1  request outstanding to the control unit
- o_IntNumber  out  2  source number for the request or chained request
- o_IntPending  out  1  another eligible interrupt waits while one is in service
- i_RegWrEn  in  1  register write strobe
- i_RegRdEn  in  1  register read strobe
- i_RegAddr  in  2  register select
- i_RegWrData  in  BUS_WIDTH  write data
- o_RegRdData  out  BUS_WIDTH  read data, registered

## Operation
- Registers:
  - 0 IER: bits[3:0] are source enables, bit 8 is GIE. Reset 0.
  - 1 IPR: bits[3:0] are pending. Read gives the pending bits; write-1-to-clear. Reset 0.
  - 2 ITR: bits[3:0] select the trigger per source, 1 = rising edge, 0 = high level. Reset 4'hF.
  - 3 ISR: read-only. Bits[1:0] are the in-service number, bit 8 is in-service active, bit 9 is request outstanding.
  - Unused bits read 0.
- Each source passes through SYNC_STAGES flops (reset 0), then one delay flop for edge detection.
- Pending set: edge mode on a synchronized rising edge; level mode every cycle the synchronized level is 1.
- Pending clear: IPR write-1, or acceptance of that source.
- A set and a clear on the same bit in the same cycle: set wins.
- eligible = pending & IER[3:0] when GIE = 1, else 0. Winner = lowest-index eligible bit.
- FSM states: ST_IDLE, ST_REQ, ST_SERVICE. Encoding 0 to 2; any other encoding returns to ST_IDLE.
  - ST_IDLE: if any bit is eligible, latch the winner into r_Number and go to ST_REQ.
  - ST_REQ: o_IntRequest=1 and r_Number is held. On i_IntAckAttended, clear pending[r_Number], set in-service = r_Number, and go to ST_SERVICE. Later changes to IER or IPR do not withdraw or alter a latched request.
  - ST_SERVICE: o_IntRequest=0. Each cycle, o_IntPending <= |eligible and r_Number <= winner (only while eligible is nonzero).
  - On i_IntAckComplete with o_IntPending=1 (tail-chain): clear pending[r_Number], set in-service = r_Number, and stay in ST_SERVICE. This matches the control unit jumping directly to the ISR for o_IntNumber.
  - On i_IntAckComplete with o_IntPending=0: go to ST_IDLE.
- No nesting: no request is raised while in ST_SERVICE.
- i_IntAckAttended is ignored outside ST_REQ. i_IntAckComplete is ignored outside ST_SERVICE.
- o_IntPending is 0 outside ST_SERVICE.
- A register write and a hardware event on the same bit in the same cycle: the hardware set wins. A write to IER takes effect on eligibility in the next cycle.

## Timing
- Reset (asynchronous, any time including mid-handshake) forces all outputs to 0, state to ST_IDLE, pending to 0, IER to 0, and ITR to 4'hF.
- Source-to-request latency: i_IrqSrc rising before edge k gives pending set at edge k+SYNC_STAGES and o_IntRequest high after edge k+SYNC_STAGES+1. With defaults, that is 4 cycles.
- o_IntRequest falls the cycle after i_IntAckAttended. Pending for that source is clear in the same cycle.
- o_IntNumber and o_IntPending are registered and lag eligibility by 1 cycle. Both are valid during any i_IntAckComplete cycle that is at least 1 cycle after the pending change.
- From ST_IDLE after a complete, a still-eligible source re-requests 1 cycle later.
- Register read: o_RegRdData is valid the cycle after i_RegRdEn and holds until the next read. Writes take effect at the strobe edge.

## Test plan
- Reset, then write IER=0x10F. Pulse i_IrqSrc[2] → o_IntRequest=1 and o_IntNumber=2 four cycles later. Then pulse i_IntAckAttended → o_IntRequest=0 next cycle and ISR reads 0x102.
- Priority: raise sources 3 and 1 in the same cycle → o_IntNumber=1. In service, o_IntPending=1 and o_IntNumber=3. On i_IntAckComplete → ISR in-service=3, IPR=0, state stays in service.
- GIE=0 with a source pending → no request. Write GIE=1 → request after 2 cycles. Clear IER bit while in ST_REQ → request still held until attended.
- Level mode (ITR=0x0) with source 0 held high → after attend and complete, re-request with number 0. Edge mode with the source held high → no second request.
- IPR write-1-to-clear on bit 1 in the same cycle as a new edge on source 1 → IPR bit 1 reads 1.
- Assert i_Rst_n=0 mid ST_REQ → all outputs and registers go to reset values immediately. No request after release until a new edge arrives.

Source files
------------

// File: rtl/int_controller.sv
// Four-source interrupt controller: synchronized sources, per-source trigger mode,
// enables with fixed priority, request/attend/complete handshake with RETI tail-chaining.
module int_controller #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUS_WIDTH   = 32
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [3:0]           i_IrqSrc,
  input  logic                 i_IntAckAttended,
  input  logic                 i_IntAckComplete,
  output logic                 o_IntRequest,
  output logic [1:0]           o_IntNumber,
  output logic                 o_IntPending,
  input  logic                 i_RegWrEn,
  input  logic                 i_RegRdEn,
  input  logic [1:0]           i_RegAddr,
  input  logic [BUS_WIDTH-1:0] i_RegWrData,
  output logic [BUS_WIDTH-1:0] o_RegRdData
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] ADDR_IER = 2'd0;
  localparam logic [1:0] ADDR_IPR = 2'd1;
  localparam logic [1:0] ADDR_ITR = 2'd2;
  localparam logic [1:0] ADDR_ISR = 2'd3;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]           dly_q, dly_d;
  logic [3:0]           pend_q, pend_d;
  logic [3:0]           ien_q, ien_d;
  logic                 gie_q, gie_d;
  logic [3:0]           itr_q, itr_d;
  logic [1:0]           state_q, state_d;
  logic [1:0]           num_q, num_d;
  logic [1:0]           isn_q, isn_d;
  logic                 ipend_q, ipend_d;
  logic [BUS_WIDTH-1:0] rd_q, rd_d;

  logic [3:0] synced, hw_set, sw_clr, ack_clr, eligible;
  logic [1:0] winner;
  logic       unused_wr_bits;

  assign unused_wr_bits = ^{i_RegWrData[BUS_WIDTH-1:9], i_RegWrData[7:4]};

  always_comb begin
    sync_d    = '0;
    sync_d[0] = i_IrqSrc;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    synced = sync_q[SYNC_STAGES-1];
    dly_d  = synced;
  end

  always_comb begin
    eligible = gie_q ? (pend_q & ien_q) : '0;
    winner   = 2'd0;
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
    else if (eligible[3]) winner = 2'd3;
  end

  // o_IntPending only tracks eligibility while remaining in service, so the
  // source just accepted never shows up as pending in the first service cycle.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    isn_d   = isn_q;
    ipend_d = 1'b0;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          num_d   = winner;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_IntAckAttended) begin
          ack_clr[num_q] = 1'b1;
          isn_d          = num_q;
          state_d        = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (i_IntAckComplete) begin
          if (ipend_q) begin
            ack_clr[num_q] = 1'b1;
            isn_d          = num_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        if (|eligible) num_d = winner;
        ipend_d = (state_d == ST_SERVICE) && (|eligible);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hardware set is OR-ed in last so it wins over both software and acceptance clears.
  always_comb begin
    hw_set = (itr_q & synced & ~dly_q) | (~itr_q & synced);
    sw_clr = (i_RegWrEn && (i_RegAddr == ADDR_IPR)) ? i_RegWrData[3:0] : '0;
    pend_d = (pend_q & ~(sw_clr | ack_clr)) | hw_set;

    ien_d = ien_q;
    gie_d = gie_q;
    itr_d = itr_q;
    if (i_RegWrEn && (i_RegAddr == ADDR_IER)) begin
      ien_d = i_RegWrData[3:0];
      gie_d = i_RegWrData[8];
    end
    if (i_RegWrEn && (i_RegAddr == ADDR_ITR)) begin
      itr_d = i_RegWrData[3:0];
    end

    rd_d = rd_q;
    if (i_RegRdEn) begin
      rd_d = '0;
      case (i_RegAddr)
        ADDR_IER: begin
          rd_d[8]   = gie_q;
          rd_d[3:0] = ien_q;
        end
        ADDR_IPR: rd_d[3:0] = pend_q;
        ADDR_ITR: rd_d[3:0] = itr_q;
        ADDR_ISR: begin
          rd_d[9]   = (state_q == ST_REQ);
          rd_d[8]   = (state_q == ST_SERVICE);
          rd_d[1:0] = isn_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q  <= '0;
      dly_q   <= '0;
      pend_q  <= '0;
      ien_q   <= '0;
      gie_q   <= 1'b0;
      itr_q   <= '1;
      state_q <= ST_IDLE;
      num_q   <= '0;
      isn_q   <= '0;
      ipend_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
      gie_q   <= gie_d;
      itr_q   <= itr_d;
      state_q <= state_d;
      num_q   <= num_d;
      isn_q   <= isn_d;
      ipend_q <= ipend_d;
      rd_q    <= rd_d;
    end
  end

  assign o_IntRequest = (state_q == ST_REQ);
  assign o_IntNumber  = num_q;
  assign o_IntPending = ipend_q;
  assign o_RegRdData  = rd_q;

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: a transaction-level reference model predicts
// per-cycle outputs and read data; a monitor pops and compares.
module tb_int_controller;
  localparam int SYNC = 2;
  localparam int BW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    src = '0;
  logic          att = 1'b0, cmp = 1'b0;
  logic          req, ipend;
  logic [1:0]    num;
  logic          wren = 1'b0, rden = 1'b0;
  logic [1:0]    addr = '0;
  logic [BW-1:0] wdata = '0;
  logic [BW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  int_controller #(.SYNC_STAGES(SYNC), .BUS_WIDTH(BW)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_IrqSrc(src),
    .i_IntAckAttended(att), .i_IntAckComplete(cmp),
    .o_IntRequest(req), .o_IntNumber(num), .o_IntPending(ipend),
    .i_RegWrEn(wren), .i_RegRdEn(rden), .i_RegAddr(addr),
    .i_RegWrData(wdata), .o_RegRdData(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sources seen through a sample history, pending as a bitmask,
  // controller phase as an integer (0 idle, 1 requesting, 2 in service).
  logic [3:0]  hist[$];
  logic [3:0]  m_en, m_itr, m_pend;
  logic        m_gie, m_ipend;
  int          m_mode;
  logic [1:0]  m_num, m_isn;
  logic [3:0]  exp_q[$];
  logic [31:0] rd_q[$];

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] read_val(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin r[8] = m_gie; r[3:0] = m_en; end
      2'd1: r[3:0] = m_pend;
      2'd2: r[3:0] = m_itr;
      default: begin r[9] = (m_mode == 1); r[8] = (m_mode == 2); r[1:0] = m_isn; end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(4'h0);
    m_en = '0; m_gie = 1'b0; m_itr = 4'hF; m_pend = '0;
    m_mode = 0; m_num = '0; m_isn = '0; m_ipend = 1'b0;
  endtask

  always @(negedge rst_n) begin
    model_reset();
    exp_q.delete();
    rd_q.delete();
  end

  always @(posedge clk) begin
    logic [3:0] lvl, rise, set, elig, clr;
    int         nmode;
    logic [1:0] nnum;
    logic       nip;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(4'h0);
    end else begin
      lvl   = hist[SYNC-1];
      rise  = lvl & ~hist[SYNC];
      set   = (m_itr & rise) | (~m_itr & lvl);
      elig  = m_gie ? (m_pend & m_en) : 4'h0;
      clr   = (wren && addr == 2'd1) ? wdata[3:0] : 4'h0;
      nmode = m_mode;
      nnum  = m_num;
      nip   = 1'b0;
      if (rden) rd_q.push_back(read_val(addr));
      if (m_mode == 0) begin
        if (elig != 0) begin nmode = 1; nnum = 2'(lowest(elig)); end
      end else if (m_mode == 1) begin
        if (att) begin clr[m_num] = 1'b1; m_isn = m_num; nmode = 2; end
      end else begin
        if (cmp && m_ipend) begin clr[m_num] = 1'b1; m_isn = m_num; end
        else if (cmp) nmode = 0;
        if (elig != 0) nnum = 2'(lowest(elig));
        nip = (nmode == 2) && (elig != 0);
      end
      m_pend = (m_pend & ~clr) | set;
      if (wren && addr == 2'd0) begin m_gie = wdata[8]; m_en = wdata[3:0]; end
      if (wren && addr == 2'd2) m_itr = wdata[3:0];
      m_mode  = nmode;
      m_num   = nnum;
      m_ipend = nip;
      hist.push_front(src);
      void'(hist.pop_back());
      exp_q.push_back({(m_mode == 1), m_ipend, m_num});
    end
  end

  // Monitor: read data is presented the cycle after a read strobe.
  logic rd_valid = 1'b0;
  always @(posedge clk) rd_valid <= rst_n && rden;

  always @(negedge clk) begin
    logic [3:0]  e;
    logic [31:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs{req,pend,num}", 32'({req, ipend, num}), 32'(e));
    end
    if (rd_valid) begin
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        chk("rd_data", rdata, r);
      end else begin
        chk("rd_data_unexpected", 32'd1, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    att = 1'b0; cmp = 1'b0; wren = 1'b0; rden = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    wren = 1'b1; addr = a; wdata = d;
    cyc();
  endtask

  task automatic reg_rd(input logic [1:0] a);
    rden = 1'b1; addr = a;
    cyc();
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!req && n < 20) begin
      cyc();
      n++;
    end
    if (!req) begin
      errors++;
      $display("FAIL wait_req: timeout, request still 0 after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("reset_req", 32'(req), 32'd0);

    // Basic request, latency, attend
    reg_wr(2'd0, 32'h10F);
    src = 4'b0100;
    n = 0;
    while (!req && n < 20) begin
      cyc();
      n++;
      if (n == 2) src = '0;
    end
    chk("latency", 32'(n), 32'd4);
    chk("first_num", 32'(num), 32'd2);
    att = 1'b1; cyc();
    chk("req_drop", 32'(req), 32'd0);
    reg_rd(2'd3);
    chk("isr_after_attend", rdata, 32'h102);
    cmp = 1'b1; cyc();

    // Priority and tail-chain
    src = 4'b1010; cyc(); cyc(); src = '0;
    wait_req(n);
    chk("prio_num", 32'(num), 32'd1);
    att = 1'b1; cyc(); cyc(); cyc();
    chk("svc_pending", 32'(ipend), 32'd1);
    chk("svc_next_num", 32'(num), 32'd3);
    cmp = 1'b1; cyc();
    reg_rd(2'd3);
    chk("isr_chained", rdata, 32'h103);
    reg_rd(2'd1);
    chk("ipr_after_chain", rdata, 32'h0);
    cmp = 1'b1; cyc();

    // Global enable gating; latched request survives IER change
    reg_wr(2'd0, 32'h00F);
    src = 4'b0001; cyc(); cyc(); src = '0;
    repeat (6) cyc();
    chk("gie_off_noreq", 32'(req), 32'd0);
    reg_wr(2'd0, 32'h10F);
    chk("gie_on_not_yet", 32'(req), 32'd0);
    cyc();
    chk("gie_on_req", 32'(req), 32'd1);
    reg_wr(2'd0, 32'h100);
    cyc(); cyc();
    chk("latched_req_held", 32'(req), 32'd1);
    chk("latched_num_held", 32'(num), 32'd0);
    att = 1'b1; cyc();
    cmp = 1'b1; cyc();
    reg_wr(2'd0, 32'h10F);

    // Level mode re-request
    reg_wr(2'd2, 32'h0);
    src = 4'b0001;
    wait_req(n);
    att = 1'b1; cyc();
    cmp = 1'b1; cyc();
    cyc();
    chk("level_rereq", 32'(req), 32'd1);
    chk("level_rereq_num", 32'(num), 32'd0);
    src = '0;
    repeat (4) cyc();
    att = 1'b1; cyc();
    cmp = 1'b1; cyc();
    repeat (3) cyc();
    reg_wr(2'd1, 32'hF);
    reg_wr(2'd2, 32'hF);
    cyc();
    if (req) begin att = 1'b1; cyc(); cmp = 1'b1; cyc(); end

    // Edge mode with source held high: single request
    src = 4'b0001;
    wait_req(n);
    att = 1'b1; cyc();
    cmp = 1'b1; cyc();
    repeat (6) cyc();
    chk("edge_no_second", 32'(req), 32'd0);
    src = '0;
    repeat (3) cyc();

    // Hardware set beats W1C on the same cycle
    reg_wr(2'd0, 32'h0);
    src = 4'b0010; repeat (3) cyc(); src = '0; repeat (3) cyc();
    src = 4'b0010; cyc(); cyc();
    reg_wr(2'd1, 32'h2);
    reg_rd(2'd1);
    chk("w1c_set_wins", rdata, 32'h2);
    reg_wr(2'd1, 32'h2);
    reg_rd(2'd1);
    chk("w1c_clears", rdata, 32'h0);
    src = '0;
    repeat (3) cyc();

    // Asynchronous reset during a request
    reg_wr(2'd0, 32'h10F);
    src = 4'b1000;
    wait_req(n);
    chk("pre_reset_num", 32'(num), 32'd3);
    src = '0;
    reg_rd(2'd0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_pend", 32'(ipend), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("post_reset_noreq", 32'(req), 32'd0);
    reg_rd(2'd0);
    chk("post_reset_ier", rdata, 32'h0);
    reg_rd(2'd2);
    chk("post_reset_itr", rdata, 32'hF);
    reg_wr(2'd0, 32'h10F);
    src = 4'b1000;
    wait_req(n);
    chk("post_reset_req_num", 32'(num), 32'd3);
    att = 1'b1; cyc();
    cmp = 1'b1; cyc();
    src = '0;

    // Randomized traffic, checked entirely by the scoreboard
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ 4'($urandom_range(0, 15));
      att = ($urandom_range(0, 2) == 0);
      cmp = ($urandom_range(0, 2) == 0);
      addr = 2'($urandom_range(0, 3));
      wren = ($urandom_range(0, 7) == 0);
      rden = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      if (addr == 2'd0 && $urandom_range(0, 3) != 0) wdata[8] = 1'b1;
      cyc();
    end
    src = '0;
    repeat (4) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
